// File: rtl/sigmoid_sample_ctrl_pkg.sv
// Shared types and constants for the RBM layer sigmoid/sample sequencer.
// Sums are Q8.4 two's complement; probabilities are Q1.7 with 0x80 = 1.0.
package sigmoid_sample_ctrl_pkg;

  localparam int DEF_INPUT_BITLENGTH = 12;
  localparam int DEF_BITLENGTH       = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CALC = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Piecewise-linear sigmoid breakpoints on |sum| in Q8.4 LSBs (5.0, 2.375, 1.0)
  localparam int SAT_MAG  = 80;
  localparam int HI_MAG   = 38;
  localparam int MID_MAG  = 16;

  // Segment offsets in Q1.7 LSBs: y = |x|/32+0.84375, |x|/8+0.625, |x|/4+0.5
  localparam int HI_OFS   = 108;
  localparam int MID_OFS  = 80;
  localparam int LO_OFS   = 64;
  localparam int PROB_ONE = 128;

endpackage

// File: rtl/sigmoid_sample_ctrl_sigmoid.sv
// Combinational piecewise-linear sigmoid: Q8.4 signed sum in, Q1.7 probability out.
// Negative inputs use the symmetry sigmoid(-x) = 1 - sigmoid(x).
module sigmoid_sample_ctrl_sigmoid
  import sigmoid_sample_ctrl_pkg::*;
#(
  parameter int input_bitlength = DEF_INPUT_BITLENGTH,
  parameter int bitlength       = DEF_BITLENGTH
) (
  input  logic [input_bitlength-1:0] sum,
  output logic [bitlength-1:0]       prob
);

  localparam int MAG_W = input_bitlength + 1;
  localparam logic [MAG_W-1:0] MAG_ONE = MAG_W'(1);

  logic             neg;
  logic [MAG_W-1:0] mag;
  logic [bitlength-1:0] pos;

  always_comb begin
    neg = sum[input_bitlength-1];
    // Extra bit so that the most negative sum still has a representable magnitude
    mag = neg ? ((~{1'b1, sum}) + MAG_ONE) : {1'b0, sum};
    if (mag >= MAG_W'(SAT_MAG)) begin
      pos = bitlength'(PROB_ONE);
    end else if (mag >= MAG_W'(HI_MAG)) begin
      pos = bitlength'(mag[6:2]) + bitlength'(HI_OFS);
    end else if (mag >= MAG_W'(MID_MAG)) begin
      pos = bitlength'(mag[5:0]) + bitlength'(MID_OFS);
    end else begin
      pos = bitlength'({mag[3:0], 1'b0}) + bitlength'(LO_OFS);
    end
    prob = neg ? (bitlength'(PROB_ONE) - pos) : pos;
  end

endmodule

// File: rtl/sigmoid_sample_ctrl.sv
// Walks one layer's pre-activation sums through a single shared sigmoid,
// Bernoulli-samples each unit and streams {idx, prob, bit} while packing h_vec.
module sigmoid_sample_ctrl
  import sigmoid_sample_ctrl_pkg::*;
#(
  parameter int NUM_UNITS       = 16,
  parameter int ADDR_W          = 4,
  parameter int input_bitlength = DEF_INPUT_BITLENGTH,
  parameter int bitlength       = DEF_BITLENGTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       sum_rd_en,
  output logic [ADDR_W-1:0]          sum_addr,
  input  logic [input_bitlength-1:0] sum_data,
  input  logic [bitlength-1:0]       rand_data,
  output logic                       rand_next,
  output logic                       smp_valid,
  input  logic                       smp_ready,
  output logic [ADDR_W-1:0]          smp_idx,
  output logic [bitlength-1:0]       smp_prob,
  output logic                       smp_bit,
  output logic [NUM_UNITS-1:0]       h_vec
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_UNITS - 1);

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      idx_reg, idx_next;
  logic [bitlength-1:0]   prob_reg;
  logic                   bit_reg;
  logic [NUM_UNITS-1:0]   h_vec_reg, h_vec_next;
  logic [bitlength-1:0]   p;
  logic                   smp_bit_next;
  logic                   clear_pass, accept, last_unit;
  logic                   unused_rand_lsb;

  sigmoid_sample_ctrl_sigmoid #(
    .input_bitlength(input_bitlength),
    .bitlength      (bitlength)
  ) u_sigmoid (
    .sum (sum_data),
    .prob(p)
  );

  // Top bitlength-1 random bits against p gives P(1) = p/128, exact at 0 and 1.0
  assign smp_bit_next    = {1'b0, rand_data[bitlength-1:1]} < p;
  assign unused_rand_lsb = rand_data[0];

  assign clear_pass = (state_reg == ST_IDLE) && start;
  assign accept     = (state_reg == ST_EMIT) && smp_ready;
  assign last_unit  = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_READ;
      ST_READ: state_next = ST_CALC;
      ST_CALC: state_next = ST_EMIT;
      ST_EMIT: if (smp_ready) state_next = last_unit ? ST_DONE : ST_READ;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    done      = (state_reg == ST_DONE);
    sum_rd_en = (state_reg == ST_READ);
    rand_next = (state_reg == ST_CALC);
    smp_valid = (state_reg == ST_EMIT);
  end

  always_comb begin
    idx_next = idx_reg;
    if (clear_pass)                idx_next = '0;
    else if (accept && !last_unit) idx_next = idx_reg + ADDR_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_hvec
      assign h_vec_next[gi] = clear_pass ? 1'b0 :
                              (accept && (idx_reg == ADDR_W'(gi))) ? bit_reg :
                              h_vec_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      prob_reg  <= '0;
      bit_reg   <= 1'b0;
      h_vec_reg <= '0;
    end else begin
      idx_reg   <= idx_next;
      h_vec_reg <= h_vec_next;
      if (state_reg == ST_CALC) begin
        prob_reg <= p;
        bit_reg  <= smp_bit_next;
      end
    end
  end

  assign sum_addr = idx_reg;
  assign smp_idx  = idx_reg;
  assign smp_prob = prob_reg;
  assign smp_bit  = bit_reg;
  assign h_vec    = h_vec_reg;

endmodule

// File: doc/sigmoid_sample_ctrl.md
# sigmoid_sample_ctrl

Sequencer that shares one combinational `sigmoid` instance across all units of an RBM layer. On `start` it walks the accumulated pre-activation sums one unit at a time, converts each to a Q1.7 probability, draws a Bernoulli sample against the uniform random source, streams `{index, probability, sample}` over a valid/ready port, and packs the samples into a layer state vector. It sits between the matrix-multiply accumulator memory and the next Gibbs iteration; the iteration loop (100–1000 passes) calls it once per layer per pass.

## Interface
- `NUM_UNITS`, 16: units per layer; must be ≥2.
- `ADDR_W`, 4: index width; ≥ clog2(`NUM_UNITS`).
- `input_bitlength`, 12: accumulated-sum width, two's complement Q8.4.
- `bitlength`, 8: probability and random width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last unit is accepted.
- `sum_rd_en`  out  1  read strobe to the sum memory.
- `sum_addr`  out  ADDR_W  unit index being read.
- `sum_data`  in  input_bitlength  read data, valid exactly one cycle after `sum_rd_en`.
- `rand_data`  in  bitlength  current uniform random word.
- `rand_next`  out  1  pulse: `rand_data` consumed; the source advances.
- `smp_valid`  out  1  output beat valid.
- `smp_ready`  in  1  consumer accepts the beat.
- `smp_idx`  out  ADDR_W  unit index of the beat.
- `smp_prob`  out  bitlength  sigmoid output, Q1.7 (0x80 = 1.0).
- `smp_bit`  out  1  sampled binary state.
- `h_vec`  out  NUM_UNITS  packed samples; bit i = unit i.

## Operation
- FSM states: IDLE, READ, CALC, EMIT, DONE.
- IDLE: on `start`, clear `idx` and `h_vec`, then go to READ. In every other state, `start` is ignored.
- READ (1 cycle): `sum_rd_en`=1 and `sum_addr`=`idx`, then go to CALC.
- CALC (1 cycle):
  - Drive `sum_data` through `sigmoid`, giving `p`.
  - Register `smp_prob`←`p`.
  - Register `smp_bit`←(`rand_data[bitlength-1:1]` < `p`), compared unsigned at bitlength width.
  - Pulse `rand_next`=1 and go to EMIT.
- Sampling consequences: p=0x80 always gives 1; p=0x00 always gives 0; P(1)=p/128.
- EMIT:
  - Hold `smp_valid`=1 with `smp_idx`=`idx`; outputs stay stable until `smp_ready`.
  - On the handshake, write `h_vec[idx]`←`smp_bit`.
  - If `idx`==`NUM_UNITS`-1, go to DONE; otherwise increment `idx` and go to READ.
- DONE (1 cycle): `done`=1, then go to IDLE. `h_vec` holds its value until the next accepted `start`.
- Arithmetic: the index compare is at full ADDR_W width and `idx` never wraps. No arithmetic on `sum_data` happens outside `sigmoid`.

## Timing
- Reset values:
  - State: IDLE.
  - `busy`, `done`, `sum_rd_en`, `rand_next`, `smp_valid`, `smp_bit`: 0.
  - `sum_addr`, `smp_idx`, `smp_prob`, `h_vec`: 0.
- All outputs are registered or decoded from state/registers only. No input drives an output combinationally.
- `start` at edge t: `sum_rd_en` at t+1, `rand_next` at t+2, `smp_valid` first high at t+3.
- Minimum 3 cycles per unit (READ, CALC, EMIT with `smp_ready` already high). Full pass with `smp_ready` tied high: 3·NUM_UNITS+1 cycles from `start` to `done`.
- Backpressure stretches EMIT only. No extra `rand_next` or `sum_rd_en` is issued while stalled.
- `smp_ready` high outside EMIT has no effect.
- Asynchronous reset mid-pass aborts immediately. No `done` is generated, and `h_vec` returns to 0.

## Structure
- Shared constants go in `config.v`: state encodings, default `bitlength`/`input_bitlength`, and the Q-format notes (sum Q8.4, probability Q1.7).
- One sub-module: the existing `sigmoid`, instantiated once with matching parameters. This block holds the only instance per layer.
- The random source stays external; its `rand_next` contract is as above.

## Test plan
- All sums 0x100, `smp_ready`=1 → each beat `smp_prob`=0x80, `smp_bit`=1; `h_vec`=all ones; `done` at start+49 for NUM_UNITS=16.
- All sums 0xF00 → each beat `smp_prob`=0x00, `smp_bit`=0; `h_vec`=0.
- Sum 0x000 with `rand_data`=0x7E → `smp_prob`=0x40, `smp_bit`=1. Sum 0x000 with `rand_data`=0x80 → `smp_bit`=0.
- `smp_ready` low for 5 cycles on unit 3 → beat stable throughout; exactly one `rand_next` and one `sum_rd_en` for that unit; indices arrive in order 0..15.
- `start` pulsed while busy → ignored; pass completes once with a single `done`.
- `rst_n` low during unit 7 → all outputs at reset values asynchronously. A new `start` after release runs a clean pass from index 0.
